// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline, including
// the MEM/WB pipeline register.
//
// Performs byte/halfword/word loads and stores against a word-organised data
// memory of 2^NB_ADDR words and sign- or zero-extends load data. Every output
// is registered and feeds WB on the following cycle (latency 1).
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_MEM_enable              pipeline step enable; 0 freezes all pipeline state
//   i_MEM_alu_result          byte address for loads/stores, pass-through otherwise
//   i_MEM_write_data          right-aligned store data
//   i_MEM_selected_reg        destination register
//   i_MEM_mem_read/_mem_write load / store strobes
//   i_MEM_byte_en/_halfword_en/_word_en  one-hot access size
//   i_MEM_unsigned            1 zero-extends loads, 0 sign-extends
//   i_MEM_reg_write/_mem_to_reg/_r31_ctrl, i_MEM_pc  WB controls, passed through
//   o_MEM_*                   registered versions of the above for WB
//   i_MEM_debug_addr, o_MEM_debug_data  debug word read port
//
// Optional feature macro: MEM_DEBUG_PORT_EN. When defined, the debug read port
// exists; when undefined, the port, its register and the second memory read
// port are absent.

module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_PC   = 32,
    parameter int NB_ADDR = 7
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_MEM_enable,
    input  logic [NB_DATA-1:0] i_MEM_alu_result,
    input  logic [NB_DATA-1:0] i_MEM_write_data,
    input  logic [NB_REG-1:0]  i_MEM_selected_reg,
    input  logic               i_MEM_mem_read,
    input  logic               i_MEM_mem_write,
    input  logic               i_MEM_byte_en,
    input  logic               i_MEM_halfword_en,
    input  logic               i_MEM_word_en,
    input  logic               i_MEM_unsigned,
    input  logic               i_MEM_reg_write,
    input  logic               i_MEM_mem_to_reg,
    input  logic               i_MEM_r31_ctrl,
    input  logic [NB_PC-1:0]   i_MEM_pc,
    output logic [NB_DATA-1:0] o_MEM_mem_data,
    output logic [NB_DATA-1:0] o_MEM_alu_result,
    output logic [NB_REG-1:0]  o_MEM_selected_reg,
    output logic               o_MEM_reg_write,
    output logic               o_MEM_mem_to_reg,
    output logic               o_MEM_r31_ctrl,
    output logic [NB_PC-1:0]   o_MEM_pc
`ifdef MEM_DEBUG_PORT_EN
    ,
    input  logic [NB_ADDR-1:0] i_MEM_debug_addr,
    output logic [NB_DATA-1:0] o_MEM_debug_data
`endif
);

    localparam int DEPTH = 1 << NB_ADDR;

    // Contents power up as zero and are deliberately never touched by reset.
    logic [NB_DATA-1:0] mem_p0 [DEPTH] = '{default: '0};

    function automatic logic [NB_DATA-1:0] extend_byte(input logic [7:0] b,
                                                       input logic uns);
        return uns ? {{(NB_DATA-8){1'b0}}, b} : {{(NB_DATA-8){b[7]}}, b};
    endfunction

    function automatic logic [NB_DATA-1:0] extend_half(input logic [15:0] h,
                                                       input logic uns);
        return uns ? {{(NB_DATA-16){1'b0}}, h} : {{(NB_DATA-16){h[15]}}, h};
    endfunction

    // Stage p0: address decode, lane selection and load extension
    logic [NB_ADDR-1:0] word_idx_p0;
    logic [1:0]         lane_p0;
    logic               size_ok_p0;
    logic [NB_DATA-1:0] rd_word_p0;
    logic [7:0]         rd_byte_p0;
    logic [15:0]        rd_half_p0;
    logic [NB_DATA-1:0] ld_data_p0;
    logic [3:0]         wr_mask_p0;
    logic [NB_DATA-1:0] wr_data_p0;
    logic               wr_en_p0;

    // Upper address bits are dropped so out-of-range accesses wrap.
    assign word_idx_p0 = i_MEM_alu_result[NB_ADDR+1:2];
    assign lane_p0     = i_MEM_alu_result[1:0];
    assign size_ok_p0  = ({i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en} == 3'b100) ||
                         ({i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en} == 3'b010) ||
                         ({i_MEM_byte_en, i_MEM_halfword_en, i_MEM_word_en} == 3'b001);
    assign rd_word_p0  = mem_p0[word_idx_p0];
    assign wr_en_p0    = !i_reset && i_MEM_enable && i_MEM_mem_write && size_ok_p0;

    always_comb begin
        rd_byte_p0 = rd_word_p0[7:0];
        case (lane_p0)
            2'd1:    rd_byte_p0 = rd_word_p0[15:8];
            2'd2:    rd_byte_p0 = rd_word_p0[23:16];
            2'd3:    rd_byte_p0 = rd_word_p0[31:24];
            default: rd_byte_p0 = rd_word_p0[7:0];
        endcase
        rd_half_p0 = lane_p0[1] ? rd_word_p0[31:16] : rd_word_p0[15:0];

        ld_data_p0 = '0;
        if (i_MEM_mem_read && size_ok_p0) begin
            if (i_MEM_byte_en)
                ld_data_p0 = extend_byte(rd_byte_p0, i_MEM_unsigned);
            else if (i_MEM_halfword_en)
                ld_data_p0 = extend_half(rd_half_p0, i_MEM_unsigned);
            else
                ld_data_p0 = rd_word_p0;
        end

        // Store data is replicated across lanes so the mask alone picks the target.
        wr_mask_p0 = 4'b0000;
        wr_data_p0 = i_MEM_write_data;
        if (i_MEM_byte_en) begin
            wr_mask_p0 = 4'b0001 << lane_p0;
            wr_data_p0 = {4{i_MEM_write_data[7:0]}};
        end else if (i_MEM_halfword_en) begin
            wr_mask_p0 = lane_p0[1] ? 4'b1100 : 4'b0011;
            wr_data_p0 = {2{i_MEM_write_data[15:0]}};
        end else if (i_MEM_word_en) begin
            wr_mask_p0 = 4'b1111;
        end
    end

    // Stage p0 -> memory: byte-lane write; the read above sees the old word.
    always_ff @(posedge i_clock) begin
        if (wr_en_p0) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_mask_p0[l])
                    mem_p0[word_idx_p0][l*8 +: 8] <= wr_data_p0[l*8 +: 8];
            end
        end
    end

    // Stage p1: MEM/WB pipeline register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_MEM_mem_data     <= '0;
            o_MEM_alu_result   <= '0;
            o_MEM_selected_reg <= '0;
            o_MEM_reg_write    <= 1'b0;
            o_MEM_mem_to_reg   <= 1'b0;
            o_MEM_r31_ctrl     <= 1'b0;
            o_MEM_pc           <= '0;
        end else if (i_MEM_enable) begin
            o_MEM_mem_data     <= ld_data_p0;
            o_MEM_alu_result   <= i_MEM_alu_result;
            o_MEM_selected_reg <= i_MEM_selected_reg;
            o_MEM_reg_write    <= i_MEM_reg_write;
            o_MEM_mem_to_reg   <= i_MEM_mem_to_reg;
            o_MEM_r31_ctrl     <= i_MEM_r31_ctrl;
            o_MEM_pc           <= i_MEM_pc;
        end
    end

`ifdef MEM_DEBUG_PORT_EN
    // Debug read runs every cycle regardless of enable so a frozen pipeline
    // can still be dumped.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            o_MEM_debug_data <= '0;
        else
            o_MEM_debug_data <= mem_p0[i_MEM_debug_addr];
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: scoreboard of expected MEM/WB contents produced by
// a byte-addressed reference model, plus directed scenarios.
module tb_mem_stage;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_PC   = 32;
    localparam int NB_ADDR = 7;
    localparam int NBYTES  = 4 * (1 << NB_ADDR);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, en, rd, wr, be, he, we, uns, rw, m2r, r31;
    logic [NB_DATA-1:0] alu, wd;
    logic [NB_REG-1:0]  sel;
    logic [NB_PC-1:0]   pc;
    logic [NB_ADDR-1:0] dbg_addr;

    logic [NB_DATA-1:0] o_mem_data, o_alu;
    logic [NB_REG-1:0]  o_sel;
    logic               o_rw, o_m2r, o_r31;
    logic [NB_PC-1:0]   o_pc;
`ifdef MEM_DEBUG_PORT_EN
    logic [NB_DATA-1:0] o_dbg;
`endif

    mem_stage #(.NB_DATA(NB_DATA), .NB_REG(NB_REG), .NB_PC(NB_PC), .NB_ADDR(NB_ADDR)) dut (
        .i_clock(clk), .i_reset(rst), .i_MEM_enable(en),
        .i_MEM_alu_result(alu), .i_MEM_write_data(wd), .i_MEM_selected_reg(sel),
        .i_MEM_mem_read(rd), .i_MEM_mem_write(wr),
        .i_MEM_byte_en(be), .i_MEM_halfword_en(he), .i_MEM_word_en(we),
        .i_MEM_unsigned(uns), .i_MEM_reg_write(rw), .i_MEM_mem_to_reg(m2r),
        .i_MEM_r31_ctrl(r31), .i_MEM_pc(pc),
        .o_MEM_mem_data(o_mem_data), .o_MEM_alu_result(o_alu),
        .o_MEM_selected_reg(o_sel), .o_MEM_reg_write(o_rw),
        .o_MEM_mem_to_reg(o_m2r), .o_MEM_r31_ctrl(o_r31), .o_MEM_pc(o_pc)
`ifdef MEM_DEBUG_PORT_EN
        , .i_MEM_debug_addr(dbg_addr), .o_MEM_debug_data(o_dbg)
`endif
    );

    typedef struct {
        logic [31:0] mem_data;
        logic [31:0] alu;
        logic [4:0]  sel;
        logic        rw, m2r, r31;
        logic [31:0] pc;
        logic [31:0] dbg;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last;
    logic [7:0]  mb [NBYTES];
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] model_word(int byte_addr);
        int b = byte_addr & (NBYTES - 4);
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
    endfunction

    // Apply one cycle of stimulus to the model, queue the expected outputs,
    // then let the clock edge happen.
    task automatic issue();
        exp_t        e;
        int          a = int'(alu) & (NBYTES - 1);
        int          n = int'(be) + int'(he) + int'(we);
        logic [31:0] ld = 32'h0;
        logic [31:0] dword = model_word(int'(dbg_addr) * 4);
        int          hb;
        if (rd && n == 1) begin
            if (we) ld = model_word(a);
            else if (he) begin
                hb = a & ~1;
                ld = {16'h0, mb[hb+1], mb[hb]};
                if (!uns && ld[15]) ld = ld | 32'hFFFF0000;
            end else begin
                ld = {24'h0, mb[a]};
                if (!uns && ld[7]) ld = ld | 32'hFFFFFF00;
            end
        end
        if (rst) begin
            e = '{32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        end else begin
            if (en) e = '{ld, alu, sel, rw, m2r, r31, pc, 32'h0};
            else    e = last;
            e.dbg = dword;
            if (en && wr && n == 1) begin
                if (we) begin
                    hb = a & ~3;
                    for (int k = 0; k < 4; k++) mb[hb+k] = wd[k*8 +: 8];
                end else if (he) begin
                    hb = a & ~1;
                    mb[hb] = wd[7:0];
                    mb[hb+1] = wd[15:8];
                end else begin
                    mb[a] = wd[7:0];
                end
            end
        end
        last = e;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; en = 1; rd = 0; wr = 0; be = 0; he = 0; we = 0; uns = 0;
        rw = 0; m2r = 0; r31 = 0; alu = 0; wd = 0; sel = 0; pc = 0; dbg_addr = 0;
    endtask

    task automatic mem_op(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] bhw, input logic u);
        rd = r; wr = w; alu = a; wd = d; {be, he, we} = bhw; uns = u;
        issue();
    endtask

    // Monitor: one expected entry per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_mem_data", o_mem_data, e.mem_data);
                chk("sb_alu", o_alu, e.alu);
                chk("sb_sel", {27'h0, o_sel}, {27'h0, e.sel});
                chk("sb_ctrl", {29'h0, o_rw, o_m2r, o_r31}, {29'h0, e.rw, e.m2r, e.r31});
                chk("sb_pc", o_pc, e.pc);
`ifdef MEM_DEBUG_PORT_EN
                chk("sb_dbg", o_dbg, e.dbg);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        for (int i = 0; i < NBYTES; i++) mb[i] = 8'h0;
        last = '{32'h0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        idle();
        @(negedge clk);

        // Reset state
        rst = 1;
        issue();
        chk("rst_mem_data", o_mem_data, 32'h0);
        chk("rst_alu", o_alu, 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        rst = 0;

        // Word store then load
        mem_op(0, 1, 32'h10, 32'hDEADBEEF, 3'b001, 0);
        mem_op(1, 0, 32'h10, 32'h0, 3'b001, 0);
        chk("word_load", o_mem_data, 32'hDEADBEEF);

        // Byte / halfword stores and extension
        mem_op(0, 1, 32'h21, 32'h000000AB, 3'b100, 0);
        mem_op(0, 1, 32'h22, 32'h00001234, 3'b010, 0);
        mem_op(1, 0, 32'h20, 32'h0, 3'b001, 0);
        chk("merge_word", o_mem_data, 32'h1234AB00);
        mem_op(1, 0, 32'h21, 32'h0, 3'b100, 0);
        chk("lb_signed", o_mem_data, 32'hFFFFFFAB);
        mem_op(1, 0, 32'h21, 32'h0, 3'b100, 1);
        chk("lbu", o_mem_data, 32'h000000AB);
        mem_op(1, 0, 32'h22, 32'h0, 3'b010, 0);
        chk("lh_signed", o_mem_data, 32'h00001234);

        // Pass-through
        sel = 5; rw = 1; r31 = 1; pc = 32'h40;
        mem_op(0, 0, 32'hBB, 32'h0, 3'b000, 0);
        chk("pt_alu", o_alu, 32'hBB);
        chk("pt_sel", {27'h0, o_sel}, 32'd5);
        chk("pt_ctrl", {30'h0, o_rw, o_r31}, 32'd3);
        chk("pt_pc", o_pc, 32'h40);
        chk("pt_mem_data", o_mem_data, 32'h0);

        // Stall: enable low, inputs changing, including a store
        en = 0;
        for (int i = 0; i < 3; i++) begin
            sel = NB_REG'($urandom); pc = $urandom;
            mem_op(1, 1, 32'h10, $urandom, 3'b001, 0);
            chk("stall_alu", o_alu, 32'hBB);
            chk("stall_pc", o_pc, 32'h40);
        end
        en = 1; sel = 0; rw = 0; r31 = 0; pc = 0;
        mem_op(1, 0, 32'h10, 32'h0, 3'b001, 0);
        chk("stall_mem_kept", o_mem_data, 32'hDEADBEEF);

        // Store suppressed by reset
        mem_op(0, 1, 32'h30, 32'h00000077, 3'b001, 0);
        rst = 1;
        mem_op(0, 1, 32'h30, 32'h00000055, 3'b001, 0);
        chk("rst2_alu", o_alu, 32'h0);
        chk("rst2_mem_data", o_mem_data, 32'h0);
        rst = 0;
        mem_op(1, 0, 32'h30, 32'h0, 3'b001, 0);
        chk("rst_store_blocked", o_mem_data, 32'h00000077);

`ifdef MEM_DEBUG_PORT_EN
        en = 0; dbg_addr = 4;
        mem_op(0, 0, 32'h0, 32'h0, 3'b000, 0);
        chk("debug_read", o_dbg, 32'hDEADBEEF);
        en = 1;
`endif

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            en  = ($urandom_range(0, 6) != 0);
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            uns = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 3) {be, he, we} = 3'b100;
            else if (r < 6) {be, he, we} = 3'b010;
            else if (r < 9) {be, he, we} = 3'b001;
            else {be, he, we} = 3'($urandom);
            alu = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
            wd = $urandom;
            sel = NB_REG'($urandom);
            rw = $urandom_range(0, 1); m2r = $urandom_range(0, 1); r31 = $urandom_range(0, 1);
            pc = $urandom;
            dbg_addr = NB_ADDR'($urandom_range(0, 17));
            issue();
        end

        idle();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
